apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for an APB master.
// One transfer in flight; completion or timeout returns status to the owner.
module apb_req_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       err0,
  output logic       err1,
  output logic       transfer,
  output logic       read_write,
  output logic [7:0] apb_write_paddr,
  output logic [7:0] apb_read_paddr,
  output logic [7:0] apb_write_data,
  input  logic       pready,
  input  logic       pslaverr,
  input  logic [7:0] prdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic       last_q;
  logic       sel_q;
  logic       rw_q;
  logic [7:0] cnt_q;
  logic       take;
  logic       win;
  logic       fin;
  logic       tmo;

  always_ff @(posedge pclk) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    win     = 1'b0;
    fin     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          take    = 1'b1;
          win     = (req0 && req1) ? !last_q : req1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // pready wins over a timeout landing in the same cycle
        if (pready) begin
          fin     = 1'b1;
          state_d = DONE;
        end else if (cnt_q == LAST_WAIT) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      last_q          <= 1'b1;
      sel_q           <= 1'b0;
      rw_q            <= 1'b0;
      cnt_q           <= '0;
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
      done0           <= 1'b0;
      done1           <= 1'b0;
      rdata0          <= '0;
      rdata1          <= '0;
      err0            <= 1'b0;
      err1            <= 1'b0;
      transfer        <= 1'b0;
      read_write      <= 1'b0;
      apb_write_paddr <= '0;
      apb_read_paddr  <= '0;
      apb_write_data  <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (take) begin
        sel_q           <= win;
        rw_q            <= win ? rw1 : rw0;
        cnt_q           <= '0;
        gnt0            <= !win;
        gnt1            <= win;
        transfer        <= 1'b1;
        read_write      <= win ? rw1 : rw0;
        apb_write_paddr <= (win ? rw1 : rw0) ? (win ? addr1 : addr0) : 8'h00;
        apb_read_paddr  <= (win ? rw1 : rw0) ? 8'h00 : (win ? addr1 : addr0);
        apb_write_data  <= win ? wdata1 : wdata0;
      end
      if (state_q == BUSY && !fin && !tmo) cnt_q <= cnt_q + 8'd1;
      if (fin || tmo) begin
        last_q          <= sel_q;
        transfer        <= 1'b0;
        read_write      <= 1'b0;
        apb_write_paddr <= '0;
        apb_read_paddr  <= '0;
        apb_write_data  <= '0;
        if (sel_q) begin
          err1 <= tmo | pslaverr;
          if (tmo)        rdata1 <= 8'h00;
          else if (!rw_q) rdata1 <= prdata;
        end else begin
          err0 <= tmo | pslaverr;
          if (tmo)        rdata0 <= 8'h00;
          else if (!rw_q) rdata0 <= prdata;
        end
      end
      if (state_q == DONE) begin
        done0 <= !sel_q;
        done1 <= sel_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a per-edge transaction model.
// Model compared every cycle on the falling edge, plus literal checkpoints.
module tb_apb_req_arbiter;

  localparam int TMO = 4;

  logic       pclk;
  logic       presetn;
  logic       req0, req1, rw0, rw1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata0, rdata1;
  logic       err0, err1;
  logic       transfer, read_write;
  logic [7:0] apb_write_paddr, apb_read_paddr, apb_write_data;
  logic       pready, pslaverr;
  logic [7:0] prdata;

  apb_req_arbiter #(.TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data),
    .pready(pready), .pslaverr(pslaverr), .prdata(prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an owner is either in flight, finishing
  // (status recorded, done pulse due), or absent.
  bit         chk_en = 0;
  bit         m_busy = 0, m_wrap = 0, m_last = 1, m_who = 0, m_rw = 0;
  int         m_wait = 0;
  logic [7:0] m_addr = 0, m_wd = 0;
  bit         e_gnt[2], e_done[2], e_err[2];
  logic [7:0] e_rdata[2];

  task automatic m_finish();
    m_busy = 0;
    m_wrap = 1;
    m_last = m_who;
  endtask

  always @(posedge pclk) begin
    if (!presetn) begin
      m_busy = 0; m_wrap = 0; m_wait = 0; m_last = 1; m_who = 0;
      m_rw = 0; m_addr = 0; m_wd = 0;
      for (int i = 0; i < 2; i++) begin
        e_gnt[i] = 0; e_done[i] = 0; e_err[i] = 0; e_rdata[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_gnt[i] = 0; e_done[i] = 0;
      end
      if (m_wrap) begin
        e_done[m_who] = 1;
        m_wrap = 0;
      end else if (m_busy) begin
        if (pready) begin
          if (!m_rw) e_rdata[m_who] = prdata;
          e_err[m_who] = pslaverr;
          m_finish();
        end else begin
          m_wait++;
          if (m_wait >= TMO) begin
            e_rdata[m_who] = 8'h00;
            e_err[m_who] = 1;
            m_finish();
          end
        end
      end else if (req0 || req1) begin
        m_who  = (req0 && req1) ? !m_last : req1;
        m_rw   = m_who ? rw1 : rw0;
        m_addr = m_who ? addr1 : addr0;
        m_wd   = m_who ? wdata1 : wdata0;
        e_gnt[m_who] = 1;
        m_busy = 1;
        m_wait = 0;
      end
    end
    chk_en = 1;
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("gnt0", gnt0, e_gnt[0]);
      chk("gnt1", gnt1, e_gnt[1]);
      chk("done0", done0, e_done[0]);
      chk("done1", done1, e_done[1]);
      chk("gnt_excl", gnt0 & gnt1, 0);
      chk("done_excl", done0 & done1, 0);
      chk("transfer", transfer, m_busy);
      if (e_done[0]) begin
        chk("rdata0", rdata0, e_rdata[0]);
        chk("err0", err0, e_err[0]);
      end
      if (e_done[1]) begin
        chk("rdata1", rdata1, e_rdata[1]);
        chk("err1", err1, e_err[1]);
      end
      if (m_busy) begin
        chk("read_write", read_write, m_rw);
        chk("wr_paddr", apb_write_paddr, m_rw ? m_addr : 8'h00);
        chk("rd_paddr", apb_read_paddr, m_rw ? 8'h00 : m_addr);
        chk("wr_data", apb_write_data, m_wd);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
    end
  endtask

  int gq[$];
  int exp_o[4] = '{0, 1, 0, 1};
  int tcount;

  initial begin
    presetn = 0; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    pready = 0; pslaverr = 0; prdata = 0;
    step(2);
    chk("reset_outs", {gnt0, gnt1, done0, done1, err0, err1, transfer,
                       read_write, rdata0, rdata1}, 0);
    chk("reset_apb", {apb_write_paddr, apb_read_paddr, apb_write_data}, 0);
    presetn = 1;
    step();

    // single write, pready in first BUSY cycle
    req0 = 1; rw0 = 1; addr0 = 8'h10; wdata0 = 8'hA5; pready = 1;
    step();
    chk("wr_gnt0", gnt0, 1);
    chk("wr_transfer", transfer, 1);
    chk("wr_paddr_lit", apb_write_paddr, 8'h10);
    chk("wr_data_lit", apb_write_data, 8'hA5);
    req0 = 0; addr0 = 8'hFF; wdata0 = 8'h00;
    step();
    chk("wr_drop", {transfer, done0}, 0);
    step();
    chk("wr_done0", done0, 1);
    chk("wr_err0", err0, 0);
    step();
    chk("wr_done_pulse", done0, 0);

    // read with two wait states
    req1 = 1; rw1 = 0; addr1 = 8'h22; pready = 0; prdata = 8'h5C;
    step();
    chk("rd_gnt1", gnt1, 1);
    chk("rd_paddr_lit", apb_read_paddr, 8'h22);
    req1 = 0;
    step(2);
    pready = 1;
    step(2);
    chk("rd_done1", done1, 1);
    chk("rd_rdata1", rdata1, 8'h5C);
    chk("rd_err1", err1, 0);
    pready = 0;
    step();

    // contention after reset: 4 transfers alternate 0,1,0,1
    presetn = 0;
    step();
    presetn = 1;
    req0 = 1; req1 = 1; rw0 = 1; rw1 = 1; pready = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
    end
    req0 = 0; req1 = 0;
    chk("rr_count", gq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < gq.size()) ? gq[i] : 99, exp_o[i]);
    step(2);

    // timeout: pready held low
    pready = 0; req0 = 1; rw0 = 0; addr0 = 8'h33;
    step();
    req0 = 0;
    tcount = transfer ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (transfer) tcount++;
    end
    chk("to_busy_cycles", tcount, 4);
    chk("to_transfer_low", transfer, 0);
    step();
    chk("to_done0", done0, 1);
    chk("to_err0", err0, 1);
    chk("to_rdata0", rdata0, 8'h00);
    step();

    // pready on the 4th BUSY cycle wins over timeout
    req0 = 1; rw0 = 0; addr0 = 8'h44; prdata = 8'h77;
    step();
    req0 = 0;
    step(3);
    pready = 1;
    step(2);
    chk("late_done0", done0, 1);
    chk("late_err0", err0, 0);
    chk("late_rdata0", rdata0, 8'h77);
    step();

    // slave error then clean read
    req1 = 1; rw1 = 1; pslaverr = 1;
    step();
    req1 = 0;
    step(2);
    chk("se_done1", done1, 1);
    chk("se_err1", err1, 1);
    pslaverr = 0;
    step();
    req1 = 1; rw1 = 0; prdata = 8'h3C;
    step();
    req1 = 0;
    step(2);
    chk("se_next_err1", err1, 0);
    chk("se_next_rdata1", rdata1, 8'h3C);
    step();

    // reset mid-BUSY
    pready = 0; req0 = 1; rw0 = 1; addr0 = 8'h55;
    step();
    req0 = 0;
    step();
    presetn = 0;
    step();
    chk("rst_mid_outs", {gnt0, gnt1, done0, done1, err0, err1, transfer,
                         read_write, rdata0, rdata1}, 0);
    presetn = 1; pready = 1;
    tcount = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done0 || done1) tcount++;
    end
    chk("rst_no_done", tcount, 0);
    req1 = 1;
    step();
    chk("rst_req1_gnt1", gnt1, 1);
    req1 = 0;
    step(3);
    req0 = 1; req1 = 1;
    step();
    chk("rst_tie_gnt0", gnt0, 1);
    req0 = 0; req1 = 0;
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
